// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-input adder and its result buffer.
package adder_pkg;

  localparam int BITS = 16;

  typedef logic [15:0] fp16_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/adder_result_ram.sv
// DEPTH x BITS storage array: one synchronous write port, one asynchronous read port.
module adder_result_ram
  import adder_pkg::*;
#(
  parameter int BITS  = adder_pkg::BITS,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem [DEPTH];

  // Store the incoming word; entries are data only and carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_fifo.sv
// Show-ahead result FIFO behind the adder: absorbs an unthrottled result stream,
// hands words to a valid/ready consumer, reports occupancy and sticky overflow.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int BITS        = adder_pkg::BITS,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic [CW-1:0]   count,
  output logic            almost_full,
  output logic            overflow,
  input  logic            clr_overflow
);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, empty;
  logic            pop, push_acc, drop;
  logic [BITS-1:0] ram_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Only a non-empty FIFO can pop, so out_ready is irrelevant while empty.
  assign pop      = !empty && out_ready;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push_acc = in_valid && (!full || pop);
  assign drop     = in_valid && full && !pop;

  adder_result_ram #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push_acc) - CW'(pop);
    overflow_d = overflow_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A drop on the same edge as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers; asynchronous reset discards every stored entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs depend only on registered state; the head is masked to zero when empty.
  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : ram_rdata;
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo at default parameters (BITS=16, DEPTH=8, AFULL_LEVEL=6).
module tb_adder_result_fifo;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  count;
  logic        almost_full;
  logic        overflow;
  logic        clr_overflow;

  int errors = 0;
  int checks = 0;

  adder_result_fifo #(
    .BITS        (16),
    .DEPTH       (8),
    .AFULL_LEVEL (6)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || almost_full !== 1'b0 ||
        overflow !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got valid=%b count=%0d af=%b ovf=%b data=%h, want 0 0 0 0 0000",
               out_valid, count, almost_full, overflow, out_data);
    end
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_data = 16'h3dc2;
    cyc();
    in_valid = 1'b0; in_data = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h3dc2 || count !== 4'd1) begin
        errors++;
        $display("FAIL single_push[%0d]: got valid=%b data=%h count=%0d, want 1 3dc2 1",
                 i, out_valid, out_data, count);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL single_drain: got valid=%b count=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_burst();
    logic [15:0] w [4];
    w[0] = 16'h3dc2; w[1] = 16'h3a2a; w[2] = 16'h4014; w[3] = 16'h3f1e;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i] || count !== 4'(4 - i)) begin
        errors++;
        $display("FAIL burst_pop[%0d]: got valid=%b data=%h count=%0d, want 1 %h %0d",
                 i, out_valid, out_data, count, w[i], 4 - i);
      end
      cyc();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL burst_empty: got valid=%b count=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_fill_overflow();
    int exp_cnt;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      cyc();
      exp_cnt = (i > 8) ? 8 : i;
      checks++;
      if (count !== 4'(exp_cnt) || almost_full !== (exp_cnt >= 6) || overflow !== (i == 9)) begin
        errors++;
        $display("FAIL fill[%0d]: got count=%0d af=%b ovf=%b, want %0d %b %b",
                 i, count, almost_full, overflow, exp_cnt, exp_cnt >= 6, i == 9);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        errors++;
        $display("FAIL fill_drain[%0d]: got valid=%b data=%h, want 1 %h", i, out_valid, out_data, 16'(i));
      end
      cyc();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_sticky: got valid=%b count=%0d ovf=%b, want 0 0 1", out_valid, count, overflow);
    end
    cyc();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold: got ovf=%b, want 1", overflow);
    end
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'h0010 + 16'(i);
      cyc();
    end
    checks++;
    if (count !== 4'd8 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL full_level: got count=%0d af=%b, want 8 1", count, almost_full);
    end
    in_data = 16'h00aa; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || out_data !== 16'h0011) begin
      errors++;
      $display("FAIL full_pushpop: got count=%0d ovf=%b data=%h, want 8 0 0011", count, overflow, out_data);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i == 7) ? 16'h00aa : 16'h0011 + 16'(i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        errors++;
        $display("FAIL full_drain[%0d]: got valid=%b data=%h, want 1 %h", i, out_valid, out_data, e);
      end
      cyc();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: got count=%0d valid=%b, want 0 0", count, out_valid);
    end
  endtask

  task automatic test_set_wins();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'h0020 + 16'(i);
      cyc();
    end
    in_data = 16'h00ee; clr_overflow = 1'b1;
    cyc();
    in_valid = 1'b0; clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8 || out_data !== 16'h0020) begin
      errors++;
      $display("FAIL set_wins: got ovf=%b count=%0d data=%h, want 1 8 0020", overflow, count, out_data);
    end
    clr_overflow = 1'b1; out_ready = 1'b1;
    repeat (8) cyc();
    clr_overflow = 1'b0; out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL set_wins_clear: got ovf=%b count=%0d, want 0 0", overflow, count);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rcv  = 0;
    for (int c = 0; c < 200 && rcv < 20; c++) begin
      in_valid  = (sent < 20) && (c % 2 == 0);
      in_data   = 16'h0100 + 16'(sent);
      out_ready = (c % 2 == 0);
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 16'h0100 + 16'(rcv)) begin
          errors++;
          $display("FAIL wrap_word[%0d]: got %h, want %h", rcv, out_data, 16'h0100 + 16'(rcv));
        end
        rcv++;
      end
      if (in_valid) sent++;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (rcv != 20 || overflow !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_done: got rcv=%0d ovf=%b count=%0d, want 20 0 0", rcv, overflow, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 16'h0200 + 16'(i);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got count=%0d ovf=%b, want 5 1", count, overflow);
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got valid=%b count=%0d ovf=%b af=%b, want 0 0 0 0",
               out_valid, count, overflow, almost_full);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 16'h3a2a;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3a2a || count !== 4'd1) begin
      errors++;
      $display("FAIL mid_first: got valid=%b data=%h count=%0d, want 1 3a2a 1", out_valid, out_data, count);
    end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
    out_ready = 1'b0; clr_overflow = 1'b0;
    test_reset();
    test_single_push();
    test_burst();
    test_fill_overflow();
    test_full_push_pop();
    test_set_wins();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
